// File: rtl/sr_div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package sr_div_pkg;

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  // ALU op encodings that route to the divider, next to ADD/OR/SRL/SLTU/SUB.
  localparam logic [2:0] ALU_DIV = 3'b101;
  localparam logic [2:0] ALU_REM = 3'b110;

endpackage

// File: rtl/sr_div_seq_if.sv
// Handshake and result bundle between the control unit and the divider.
interface sr_div_seq_if #(parameter int WIDTH = 32);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, srcA, srcB,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, srcA, srcB,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/sr_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep the difference when it is non-negative.
module sr_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The shifted partial remainder can exceed WIDTH bits when the divisor is
  // above 2^(WIDTH-1); since it stays below 2*divisor, the extra bit of the
  // difference is a valid borrow.
  always_comb begin
    shifted  = {rem, dvd_msb};
    diff     = shifted - {1'b0, divisor};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/sr_div_seq.sv
// Radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU semantics,
// one quotient bit per clock, for the schoolRISCV datapath.
//
// state | meaning
// IDLE  | waiting for start, results held
// RUN   | one restoring step per cycle, cnt counts down to 0
// DONE  | results valid, done high; a new start is accepted here
module sr_div_seq
  import sr_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic         clk,
  input logic         rst_n,
  sr_div_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE = DIV_IDLE;
  localparam logic [1:0] ST_RUN  = DIV_RUN;
  localparam logic [1:0] ST_DONE = DIV_DONE;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem_acc;
  logic             neg_q;
  logic             neg_r;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic             b_zero;
  logic [WIDTH-1:0] rem_nx;
  logic             q_bit;
  logic [WIDTH-1:0] q_final;

  assign a_neg  = bus.is_signed & bus.srcA[WIDTH-1];
  assign b_neg  = bus.is_signed & bus.srcB[WIDTH-1];
  assign a_abs  = a_neg ? -bus.srcA : bus.srcA;
  assign b_abs  = b_neg ? -bus.srcB : bus.srcB;
  assign b_zero = (bus.srcB == '0);

  sr_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_acc),
    .dvd_msb  (dvd[WIDTH-1]),
    .divisor  (dvs),
    .rem_next (rem_nx),
    .q_bit    (q_bit)
  );

  // Quotient bits shift into the vacated low end of the dividend register.
  assign q_final = {dvd[WIDTH-2:0], q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      dvd             <= '0;
      dvs             <= '0;
      rem_acc         <= '0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          bus.done <= 1'b0;
          if (bus.start && b_zero) begin
            state           <= ST_DONE;
            bus.done        <= 1'b1;
            bus.quotient    <= '1;
            bus.remainder   <= bus.srcA;
            bus.div_by_zero <= 1'b1;
          end else if (bus.start) begin
            state           <= ST_RUN;
            bus.busy        <= 1'b1;
            dvd             <= a_abs;
            dvs             <= b_abs;
            rem_acc         <= '0;
            cnt             <= CNT_W'(WIDTH - 1);
            neg_q           <= a_neg ^ b_neg;
            neg_r           <= a_neg;
            bus.div_by_zero <= 1'b0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          rem_acc <= rem_nx;
          dvd     <= q_final;
          if (cnt == '0) begin
            state         <= ST_DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.quotient  <= neg_q ? -q_final : q_final;
            bus.remainder <= neg_r ? -rem_nx : rem_nx;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule
